// File: rtl/sdram_rw_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_rw_ctrl
//   Arbitrates burst writes (write FIFO -> SDRAM) and burst reads
//   (SDRAM -> read FIFO) in front of an SDRAM driver. Each access is
//   BURST_LEN words. Write and read keep independent linear word pointers
//   that wrap at FRAME_WORDS. Reads are enabled once the first full frame
//   has been written. When both directions are pending, service alternates.
//
//   Optional feature macro: SDRAM_PINGPONG_EN
//     defined   : write bank toggles 0/1 per completed frame; read bank
//                 follows the last fully written bank.
//     undefined : single buffer, both banks fixed at 0.
//
// Ports
//   clk, rst_n       : 100 MHz clock, async active-low reset
//   initial_done     : SDRAM init complete
//   busy             : driver busy
//   ack              : driver accepted the current request (1 cycle)
//   rd_dout/_vld     : driver read data / valid
//   wr_req, rd_req   : request strobes to the driver (held until ack)
//   rw_addr          : {bank[1:0], row[12:0], col[8:0]} of the active request
//   wr_din/_vld      : write data to the driver
//   wfifo_q/_usedw   : write-FIFO show-ahead head word / fill level
//   wfifo_rdreq      : write-FIFO pop
//   rfifo_usedw      : read-FIFO fill level
//   rfifo_wrreq/data : read-FIFO push / data
//   wr_frame_done    : one-cycle pulse when the write pointer wraps
// ---------------------------------------------------------------------------
module sdram_rw_ctrl #(
    parameter int unsigned BURST_LEN   = 8,
    parameter int unsigned FRAME_WORDS = 307200,
    parameter int unsigned RFIFO_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        initial_done,
    input  logic        busy,
    input  logic        ack,
    input  logic [15:0] rd_dout,
    input  logic        rd_dout_vld,
    output logic        wr_req,
    output logic        rd_req,
    output logic [23:0] rw_addr,
    output logic [15:0] wr_din,
    output logic        wr_din_vld,
    input  logic [15:0] wfifo_q,
    input  logic [10:0] wfifo_usedw,
    output logic        wfifo_rdreq,
    input  logic [10:0] rfifo_usedw,
    output logic        rfifo_wrreq,
    output logic [15:0] rfifo_data,
    output logic        wr_frame_done
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [21:0]      PTR_STEP  = 22'(BURST_LEN);
    localparam logic [21:0]      PTR_END   = 22'(FRAME_WORDS);
    localparam logic [10:0]      WR_THRESH = 11'(BURST_LEN);
    localparam logic [10:0]      RD_THRESH = 11'(RFIFO_DEPTH - 2 * BURST_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_DATA,
        ST_RD_REQ,
        ST_RD_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [21:0]      r_wr_ptr;
    logic [21:0]      r_rd_ptr;
    logic             r_rd_enable;
    logic             r_last_wr;
    logic             r_wr_frame_done;
    logic [1:0]       w_wr_bank;
    logic [1:0]       w_rd_bank;

    logic        w_wr_pend;
    logic        w_rd_pend;
    logic        w_wr_beat;
    logic        w_rd_beat;
    logic        w_wr_done;
    logic        w_rd_done;
    logic [21:0] w_wr_ptr_nxt;
    logic [21:0] w_rd_ptr_nxt;
    logic        w_wr_wrap;
    logic        w_rd_wrap;

    assign w_wr_pend = (wfifo_usedw >= WR_THRESH);
    assign w_rd_pend = r_rd_enable && (rfifo_usedw <= RD_THRESH);

    // The ack cycle is write word 0, so the beat counter is shared between the
    // ack cycle in WR_REQ and the remaining WR_DATA cycles. r_cnt is always 0
    // on entry to a request state, which also covers BURST_LEN == 1.
    assign w_wr_beat = ((r_state == ST_WR_REQ) && ack) || (r_state == ST_WR_DATA);
    assign w_rd_beat = (r_state == ST_RD_WAIT) && rd_dout_vld;
    assign w_wr_done = w_wr_beat && (r_cnt == CNT_LAST);
    assign w_rd_done = w_rd_beat && (r_cnt == CNT_LAST);

    assign w_wr_ptr_nxt = r_wr_ptr + PTR_STEP;
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_STEP;
    assign w_wr_wrap    = (w_wr_ptr_nxt >= PTR_END);
    assign w_rd_wrap    = (w_rd_ptr_nxt >= PTR_END);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (initial_done && !busy) begin
                    // Round-robin: a lone pending side wins; with both
                    // pending, serve the side that was not served last.
                    if (w_wr_pend && (!w_rd_pend || !r_last_wr)) begin
                        w_next_state = ST_WR_REQ;
                    end else if (w_rd_pend) begin
                        w_next_state = ST_RD_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (ack) begin
                    w_next_state = w_wr_done ? ST_IDLE : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                if (w_wr_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (ack) begin
                    w_next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (w_rd_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from state so reset clears them immediately.
    always_comb begin
        wr_req      = (r_state == ST_WR_REQ);
        rd_req      = (r_state == ST_RD_REQ);
        wfifo_rdreq = w_wr_beat;
        wr_din_vld  = w_wr_beat;
        wr_din      = w_wr_beat ? wfifo_q : '0;
        rfifo_wrreq = w_rd_beat;
        rfifo_data  = w_rd_beat ? rd_dout : '0;
        rw_addr     = '0;
        case (r_state)
            ST_WR_REQ, ST_WR_DATA: rw_addr = {w_wr_bank, r_wr_ptr};
            ST_RD_REQ, ST_RD_WAIT: rw_addr = {w_rd_bank, r_rd_ptr};
            default:               rw_addr = '0;
        endcase
    end

    assign wr_frame_done = r_wr_frame_done;

    // Beat counter, pointers, read enable, arbitration history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_rd_enable     <= 1'b0;
            r_last_wr       <= 1'b0;
            r_wr_frame_done <= 1'b0;
        end else begin
            r_wr_frame_done <= 1'b0;

            if (w_wr_beat) begin
                r_cnt <= w_wr_done ? '0 : r_cnt + 1'b1;
            end else if (w_rd_beat) begin
                r_cnt <= w_rd_done ? '0 : r_cnt + 1'b1;
            end

            if (w_wr_done) begin
                r_wr_ptr <= w_wr_wrap ? '0 : w_wr_ptr_nxt;
                if (w_wr_wrap) begin
                    r_wr_frame_done <= 1'b1;
                    r_rd_enable     <= 1'b1;
                end
            end

            if (w_rd_done) begin
                r_rd_ptr <= w_rd_wrap ? '0 : w_rd_ptr_nxt;
            end

            if (r_state == ST_IDLE) begin
                if (w_next_state == ST_WR_REQ) begin
                    r_last_wr <= 1'b1;
                end else if (w_next_state == ST_RD_REQ) begin
                    r_last_wr <= 1'b0;
                end
            end
        end
    end

`ifdef SDRAM_PINGPONG_EN
    logic [1:0] r_wr_bank;
    logic [1:0] r_rd_bank;
    logic [1:0] r_full_bank;

    // r_full_bank remembers the most recently completed bank; the read side
    // picks it up at its own frame boundary so a frame is never torn.
    // On the first wrap the read side is not yet enabled, so it takes the
    // just-completed bank directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_bank   <= '0;
            r_rd_bank   <= '0;
            r_full_bank <= '0;
        end else begin
            if (w_wr_done && w_wr_wrap) begin
                r_wr_bank   <= {1'b0, ~r_wr_bank[0]};
                r_full_bank <= r_wr_bank;
                if (!r_rd_enable) begin
                    r_rd_bank <= r_wr_bank;
                end
            end
            if (w_rd_done && w_rd_wrap) begin
                r_rd_bank <= r_full_bank;
            end
        end
    end

    assign w_wr_bank = r_wr_bank;
    assign w_rd_bank = r_rd_bank;
`else
    assign w_wr_bank = '0;
    assign w_rd_bank = '0;
`endif

endmodule

// File: tb/tb_sdram_rw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sdram_rw_ctrl
//   Scoreboard bench for sdram_rw_ctrl (FRAME_WORDS = 32). The main process
//   plays the SDRAM driver and pushes expected requests / data words into
//   queues; a negedge monitor pops and compares whenever the DUT presents a
//   new request, a write-FIFO pop or a read-FIFO push.
// ---------------------------------------------------------------------------
module tb_sdram_rw_ctrl;

    localparam int unsigned BL = 8;
`ifdef SDRAM_PINGPONG_EN
    localparam logic [1:0] WB1 = 2'd1;  // write bank in the second frame
`else
    localparam logic [1:0] WB1 = 2'd0;
`endif
    localparam logic [1:0] RB = 2'd0;   // read bank after the first frame

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        initial_done = 1'b0;
    logic        busy = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] rd_dout = '0;
    logic        rd_dout_vld = 1'b0;
    logic        wr_req, rd_req;
    logic [23:0] rw_addr;
    logic [15:0] wr_din;
    logic        wr_din_vld;
    logic [15:0] wfifo_q;
    logic [10:0] wfifo_usedw = 11'd100;
    logic        wfifo_rdreq;
    logic [10:0] rfifo_usedw = 11'd0;
    logic        rfifo_wrreq;
    logic [15:0] rfifo_data;
    logic        wr_frame_done;

    always #5 clk = ~clk;

    sdram_rw_ctrl #(
        .BURST_LEN  (BL),
        .FRAME_WORDS(32),
        .RFIFO_DEPTH(1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .initial_done (initial_done),
        .busy         (busy),
        .ack          (ack),
        .rd_dout      (rd_dout),
        .rd_dout_vld  (rd_dout_vld),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .rw_addr      (rw_addr),
        .wr_din       (wr_din),
        .wr_din_vld   (wr_din_vld),
        .wfifo_q      (wfifo_q),
        .wfifo_usedw  (wfifo_usedw),
        .wfifo_rdreq  (wfifo_rdreq),
        .rfifo_usedw  (rfifo_usedw),
        .rfifo_wrreq  (rfifo_wrreq),
        .rfifo_data   (rfifo_data),
        .wr_frame_done(wr_frame_done)
    );

    // Show-ahead write FIFO model: head word advances on each pop.
    logic [15:0] wq = 16'h0010;
    always @(posedge clk) if (wfifo_rdreq) wq <= wq + 16'd1;
    assign wfifo_q = wq;

    logic [24:0] exp_req[$];   // {is_read, rw_addr}
    logic [15:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    int checks = 0;
    int errors = 0;
    int fd_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event expected=none t=%0t", name, $time);
    endtask

    // Monitor
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        logic [24:0] e;
        if (wr_req || rd_req) check("req_exclusive", {31'd0, wr_req & rd_req}, 32'd0);
        if ((wr_req || rd_req) && !prev_req) begin
            if (exp_req.size() == 0) flag("req_unexpected");
            else begin
                e = exp_req.pop_front();
                check("req_type", {31'd0, rd_req}, {31'd0, e[24]});
                check("req_addr", {8'd0, rw_addr}, {8'd0, e[23:0]});
            end
        end
        prev_req <= wr_req || rd_req;
        if (wfifo_rdreq) begin
            check("wr_din_vld", {31'd0, wr_din_vld}, 32'd1);
            if (exp_wr.size() == 0) flag("wr_unexpected");
            else check("wr_din", {16'd0, wr_din}, {16'd0, exp_wr.pop_front()});
        end
        if (rfifo_wrreq) begin
            if (exp_rd.size() == 0) flag("rd_push_unexpected");
            else check("rfifo_data", {16'd0, rfifo_data}, {16'd0, exp_rd.pop_front()});
        end
        if (wr_frame_done) fd_count <= fd_count + 1;
    end

    task automatic outputs_zero(input string tag);
        check({tag, "_ctl"}, {26'd0, wr_req, rd_req, wr_din_vld, wfifo_rdreq, rfifo_wrreq, wr_frame_done}, 32'd0);
        check({tag, "_addr"}, {8'd0, rw_addr}, 32'd0);
        check({tag, "_wr_din"}, {16'd0, wr_din}, 32'd0);
        check({tag, "_rfifo_data"}, {16'd0, rfifo_data}, 32'd0);
    endtask

    task automatic wait_req();
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wr_req || rd_req) begin ok = 1; break; end
        end
        if (!ok) flag("req_timeout");
    endtask

    task automatic serve_wr(input bit drop);
        wait_req();
        @(posedge clk); #1 ack = 1'b1;
        if (drop) begin
            wfifo_usedw = 11'd0;
            rfifo_usedw = 11'd1010;
        end
        @(posedge clk); #1 ack = 1'b0;
        repeat (BL - 1) @(posedge clk);
        #1;
    endtask

    task automatic serve_rd(input logic [15:0] base, input bit stray);
        wait_req();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        for (int i = 0; i < BL; i++) begin
            rd_dout_vld = 1'b1;
            rd_dout = base + 16'(i);
            @(posedge clk); #1;
        end
        rd_dout_vld = 1'b0;
        rd_dout = '0;
        if (stray) begin
            rd_dout_vld = 1'b1;
            rd_dout = 16'h00EE;
            @(negedge clk);
            check("stray_no_push", {31'd0, rfifo_wrreq}, 32'd0);
            @(posedge clk); #1 rd_dout_vld = 1'b0;
        end
    endtask

    initial begin
        bit seen;
        // Reset state
        #12 outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // Init gating: writes pending but SDRAM not ready
        repeat (5) @(negedge clk);
        check("init_gate_wr_req", {31'd0, wr_req}, 32'd0);

        exp_req.push_back({1'b0, 2'd0, 22'd0});
        exp_req.push_back({1'b0, 2'd0, 22'd8});
        exp_req.push_back({1'b0, 2'd0, 22'd16});
        exp_req.push_back({1'b0, 2'd0, 22'd24});
        exp_req.push_back({1'b1, RB,   22'd0});
        exp_req.push_back({1'b0, WB1,  22'd0});
        exp_req.push_back({1'b1, RB,   22'd8});
        exp_req.push_back({1'b0, WB1,  22'd8});
        for (int i = 0; i < 48; i++) exp_wr.push_back(16'h0010 + 16'(i));
        for (int i = 0; i < 8; i++) exp_rd.push_back(16'h00A0 + 16'(i));
        for (int i = 0; i < 8; i++) exp_rd.push_back(16'h00B0 + 16'(i));

        @(posedge clk); #1 initial_done = 1'b1;

        // First frame: four write bursts
        repeat (4) serve_wr(1'b0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (wr_frame_done) begin seen = 1; break; end
        end
        check("frame_done_pulse", {31'd0, seen}, 32'd1);
        @(negedge clk);
        check("frame_done_one_cycle", {31'd0, wr_frame_done}, 32'd0);

        // Both pending: read, write, read, write
        serve_rd(16'h00A0, 1'b1);
        serve_wr(1'b0);
        serve_rd(16'h00B0, 1'b0);
        serve_wr(1'b1);   // pending conditions drop in the ack cycle

        // Read FIFO too full (1010) and no write data: nothing issued
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | wr_req | rd_req;
        end
        check("rfifo_full_no_req", {31'd0, seen}, 32'd0);

        // Reset during WR_DATA word 3
        exp_req.push_back({1'b0, WB1, 22'd16});
        for (int i = 0; i < 3; i++) exp_wr.push_back(16'h0040 + 16'(i));
        wfifo_usedw = 11'd100;
        wait_req();
        @(posedge clk); #1 ack = 1'b1;
        @(posedge clk); #1 ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        #1 outputs_zero("reset_mid_burst");
        exp_req.push_back({1'b0, 2'd0, 22'd0});
        for (int i = 0; i < 8; i++) exp_wr.push_back(16'h0043 + 16'(i));
        rfifo_usedw = 11'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        serve_wr(1'b1);
        repeat (5) @(negedge clk);

        check("exp_req_drained", exp_req.size(), 32'd0);
        check("exp_wr_drained", exp_wr.size(), 32'd0);
        check("exp_rd_drained", exp_rd.size(), 32'd0);
        check("frame_done_count", fd_count, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_rw_ctrl.md
SDRAM_RW_CTRL -- requirements
Module: sdram_rw_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low, ports named clk and rst_n.
REQ-002 The block SHALL provide these parameters:
- BURST_LEN, 8, words per SDRAM access.
- FRAME_WORDS, 307200, words per frame buffer (multiple of BURST_LEN).
- RFIFO_DEPTH, 1024, read-FIFO capacity in words.
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  async active-low reset.
- initial_done  in  1  SDRAM init complete.
- busy  in  1  driver busy.
- ack  in  1  driver accepted current request (single-cycle).
- rd_dout  in  16  driver read data.
- rd_dout_vld  in  1  driver read data valid.
- wr_req  out  1  write request.
- rd_req  out  1  read request.
- rw_addr  out  24  {bank[1:0], row[12:0], col[8:0]}.
- wr_din  out  16  write data.
- wr_din_vld  out  1  write data valid.
- wfifo_q  in  16  write-FIFO show-ahead head word.
- wfifo_usedw  in  11  write-FIFO fill level.
- wfifo_rdreq  out  1  write-FIFO pop.
- rfifo_usedw  in  11  read-FIFO fill level.
- rfifo_wrreq  out  1  read-FIFO push.
- rfifo_data  out  16  read-FIFO data.
- wr_frame_done  out  1  one-cycle pulse when a full frame is written.

Function
REQ-004 FSM states: IDLE, WR_REQ, WR_DATA, RD_REQ, RD_WAIT.
REQ-005 Write pending SHALL mean wfifo_usedw >= BURST_LEN.
REQ-006 Read pending SHALL mean rd_enable=1 and rfifo_usedw <= RFIFO_DEPTH-2*BURST_LEN.
REQ-007 rd_enable SHALL be 0 until the first wr_frame_done, then 1 until reset.
REQ-008 IDLE SHALL leave only when initial_done=1 and busy=0.
REQ-009 From IDLE, the block SHALL go to WR_REQ if only a write is pending, to RD_REQ if only a read is pending, and otherwise to the type not served last (round-robin; reset favours write).
REQ-010 In WR_REQ, wr_req SHALL be held at 1 until the ack cycle.
REQ-011 In the ack cycle, the block SHALL assert wfifo_rdreq and wr_din_vld, with wr_din = wfifo_q; that cycle is word 0.
REQ-012 The block SHALL continue in WR_DATA for exactly BURST_LEN consecutive cycles total, then return to IDLE.
REQ-013 In RD_REQ, rd_req SHALL be held at 1 until ack, then the FSM SHALL go to RD_WAIT.
REQ-014 In RD_WAIT, each rd_dout_vld SHALL produce rfifo_wrreq=1 with rfifo_data=rd_dout in the same cycle.
REQ-015 RD_WAIT SHALL exit to IDLE after BURST_LEN valid words have been counted.
REQ-016 wr_req and rd_req SHALL never be asserted together.
REQ-017 Write and read each SHALL have a 22-bit linear word pointer; rw_addr[21:0] = the pointer of the active request, and rw_addr[23:22] = the active bank.
REQ-018 After a burst completes, its pointer SHALL advance by BURST_LEN.
REQ-019 When a pointer reaches FRAME_WORDS it SHALL wrap to 0.
REQ-020 wr_frame_done SHALL pulse for one cycle on the write-pointer wrap.
REQ-021 If ack arrives in the same cycle that a pending condition drops, the access SHALL still complete in full.
REQ-022 rd_dout_vld outside RD_WAIT SHALL be ignored and SHALL NOT push to the read FIFO.

Reset
REQ-023 On rst_n=0, the block SHALL immediately:
- set the FSM to IDLE;
- set all outputs to 0, including rw_addr=0 and wr_din=0;
- clear both pointers, rd_enable, and the round-robin flag;
- abandon any burst in progress with no further FIFO pops or pushes.

Configuration
REQ-024 Macro SDRAM_PINGPONG_EN SHALL select buffering:
- Defined: the write bank starts at 0 and toggles 0/1 on each wr_frame_done; the read bank is the last fully written bank, latched when the read pointer wraps or when rd_enable first rises.
- Undefined: both banks are fixed at 0 (single buffer).

Verification
REQ-025 Init gating: initial_done=0, wfifo_usedw=100 -> wr_req stays 0; set initial_done=1 -> wr_req=1, rw_addr=0.
REQ-026 Write burst: ack pulse with wfifo_q incrementing 0x10.. -> 8 consecutive wfifo_rdreq/wr_din_vld cycles, wr_din 0x10..0x17, next rw_addr=8.
REQ-027 Read burst: with rd_enable=1, ack, then 8 rd_dout_vld with 0xA0..0xA7 -> 8 rfifo_wrreq with the same data, then IDLE; stray rd_dout_vld afterwards -> no push.
REQ-028 Arbitration: both write and read pending continuously -> requests alternate W,R,W,R; rfifo_usedw=1010 -> no rd_req.
REQ-029 Frame wrap (FRAME_WORDS=32 in the bench): 4 write bursts -> wr_frame_done pulse, write pointer=0, with SDRAM_PINGPONG_EN the write bank becomes 1 and the read bank 0; without it, both banks stay 0.
REQ-030 Reset in WR_DATA at word 3 -> wfifo_rdreq=0 immediately, all outputs 0; after release, the next write starts at rw_addr=0.
